mux_sel_rr_arbiter: RTL

//  Round-robin arbiter sharing one 4:1 N-bit datapath mux among four requesters
//  (hash engine stages / load units). Grants exclusive ownership, drives the mux Sel

---
 rtl/mux_sel_rr_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mux_sel_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_rr_arbiter
//
// Round-robin arbiter that shares one 4:1 datapath mux among four requesters.
// One requester at a time owns the mux. Sel follows the owner and is held
// after release so the mux output does not move until the next owner is
// granted. Every release is followed by one dead (GAP) cycle that lets the
// mux output settle.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, an owner that holds the mux for MAX_HOLD cycles without
//   releasing is forced off and Timeout pulses for one cycle. When undefined,
//   no hold counter is built, ownership is unbounded and Timeout is tied low.
//   The port list is the same in both builds.
//
// Parameters:
//   MAX_HOLD - owned cycles before forced release (ARB_TIMEOUT_EN only)
//   CNT_W    - hold-counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst      in   asynchronous active-high reset
//   Req[3:0] in   Req[i]=1: requester i wants the mux, held until done
//   Done[3:0]in   one-cycle release pulse; only the owner's bit is honoured
//   Grant    out  registered one-hot owner, 4'b0000 when nobody owns the mux
//   Sel      out  registered mux select = index of current/last owner
//   Busy     out  registered, high while any Grant bit is set
//   Timeout  out  registered one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module mux_sel_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic [3:0] Done,
  output logic [3:0] Grant,
  output logic [1:0] Sel,
  output logic       Busy,
  output logic       Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [1:0] last, last_next;
  logic [3:0] grant_next;
  logic [1:0] sel_next;
  logic       busy_next;

  logic [1:0] pick;
  logic       pick_valid;
  logic       release_normal;
  logic       expired;

  // Round-robin pick: scan last+1, last+2, last+3, last. The loop runs from
  // the lowest priority (offset 4 == last itself) up to the highest (offset
  // 1), so the last match written is the winner.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (Req[last + 2'(k)]) begin
        pick       = last + 2'(k);
        pick_valid = 1'b1;
      end
    end
  end

  // Owner gives up the mux by pulsing its Done bit or dropping its request.
  assign release_normal = Done[Sel] | ~Req[Sel];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  // hold_cnt equals the number of owned cycles already completed, so it
  // reaches MAX_HOLD-1 during the last cycle the owner is allowed to keep.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold_cnt <= '0;
    end else if (state != OWN) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // A normal release on the expiry cycle wins, so no Timeout pulse then.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Timeout <= 1'b0;
    end else begin
      Timeout <= (state == OWN) && expired && !release_normal;
    end
  end
`else
  assign expired = 1'b0;
  assign Timeout = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_next = state;
    grant_next = Grant;
    sel_next   = Sel;
    busy_next  = Busy;
    last_next  = last;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next = 4'(4'b0001 << pick);
          sel_next   = pick;
          busy_next  = 1'b1;
          state_next = OWN;
        end
      end
      OWN: begin
        if (release_normal || expired) begin
          // Sel is deliberately left alone so the mux output stays put.
          grant_next = 4'b0000;
          busy_next  = 1'b0;
          last_next  = Sel;
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        grant_next = 4'b0000;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Last resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state <= IDLE;
      Grant <= 4'b0000;
      Sel   <= 2'd0;
      Busy  <= 1'b0;
      last  <= 2'd3;
    end else begin
      state <= state_next;
      Grant <= grant_next;
      Sel   <= sel_next;
      Busy  <= busy_next;
      last  <= last_next;
    end
  end

endmodule
